// File: rtl/cve2_rf_pkg.sv
// cve2_rf_pkg: shared widths, writeback record and x0 helper for the register-file writeback path
package cve2_rf_pkg;
   localparam int unsigned RfAddrW      = 5;
   localparam int unsigned NumRfWrPorts = 2;
   localparam int unsigned RfDataW      = 32;
   typedef struct packed {
      logic [RfAddrW-1:0] addr;
      logic [RfDataW-1:0] data;
      logic               we;
   } rf_wr_t;
   // under RV32E the upper half of the address space aliases x0
   function automatic logic is_zero_reg(logic [RfAddrW-1:0] a, bit rv32e);
      return a == '0 || (rv32e && a[4]);
   endfunction
endpackage

// File: rtl/cve2_rf_wb_arbiter_if.sv
// cve2_rf_wb_arbiter_if: writeback requests, register-file write ports, reservations and hazard lookups
interface cve2_rf_wb_arbiter_if import cve2_rf_pkg::*; #(
   parameter int unsigned NumReq    = 3,
   parameter int unsigned DataWidth = 32
);
   logic [NumReq-1:0]                req_valid_i;
   logic [NumReq-1:0]                req_ready_o;
   logic [NumReq-1:0][RfAddrW-1:0]   req_addr_i;
   logic [NumReq-1:0][DataWidth-1:0] req_data_i;
   logic                             we_a_o;
   logic [RfAddrW-1:0]               waddr_a_o;
   logic [DataWidth-1:0]             wdata_a_o;
   logic                             we_b_o;
   logic [RfAddrW-1:0]               waddr_b_o;
   logic [DataWidth-1:0]             wdata_b_o;
   logic                             rsv_valid_i;
   logic [RfAddrW-1:0]               rsv_addr_i;
   logic                             rsv_ready_o;
   logic                             flush_i;
   logic [RfAddrW-1:0]               raddr_a_i;
   logic [RfAddrW-1:0]               raddr_b_i;
   logic [RfAddrW-1:0]               raddr_c_i;
   logic                             hz_a_o;
   logic                             hz_b_o;
   logic                             hz_c_o;
   modport master (
      output req_valid_i, req_addr_i, req_data_i, rsv_valid_i, rsv_addr_i, flush_i,
             raddr_a_i, raddr_b_i, raddr_c_i,
      input  req_ready_o, we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o,
             rsv_ready_o, hz_a_o, hz_b_o, hz_c_o
   );
   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, rsv_valid_i, rsv_addr_i, flush_i,
             raddr_a_i, raddr_b_i, raddr_c_i,
      output req_ready_o, we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o,
             rsv_ready_o, hz_a_o, hz_b_o, hz_c_o
   );
endinterface

// File: rtl/cve2_rf_rr_pick2.sv
// cve2_rf_rr_pick2: circular two-winner picker; the second winner must target a different register
module cve2_rf_rr_pick2 import cve2_rf_pkg::*; #(
   parameter int unsigned NumReq = 3,
   parameter int unsigned IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]              valid_i,
   input  logic [NumReq-1:0][RfAddrW-1:0] addr_i,
   input  logic [IdxW-1:0]                rr_i,
   output logic [NumReq-1:0]              gnt_o,
   output logic [IdxW-1:0]                idx_a_o,
   output logic [IdxW-1:0]                idx_b_o,
   output logic                           vld_b_o
);
   logic            vld_a;
   logic [IdxW-1:0] j;
   always_comb begin
      gnt_o   = '0;
      idx_a_o = '0;
      idx_b_o = '0;
      vld_a   = 1'b0;
      vld_b_o = 1'b0;
      j       = '0;
      for (int k = 0; k < NumReq; k++) begin
         j = IdxW'((int'(rr_i) + k) % NumReq);
         if (valid_i[j] && !vld_a) begin
            vld_a    = 1'b1;
            idx_a_o  = j;
            gnt_o[j] = 1'b1;
         end else if (valid_i[j] && !vld_b_o && addr_i[j] != addr_i[idx_a_o]) begin
            vld_b_o  = 1'b1;
            idx_b_o  = j;
            gnt_o[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cve2_rf_wb_arbiter.sv
// cve2_rf_wb_arbiter: grants up to two writebacks per cycle into a registered RF write stage and tracks pending writes
module cve2_rf_wb_arbiter import cve2_rf_pkg::*; #(
   parameter bit          RV32E     = 1'b0,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumReq    = 3
) (
   input logic              clk_i,
   input logic              rst_ni,
   cve2_rf_wb_arbiter_if.slave bus
);
   localparam int unsigned IdxW    = $clog2(NumReq);
   localparam int unsigned RegW    = RV32E ? 4 : 5;
   localparam int unsigned NumRegs = 1 << RegW;
   logic [IdxW-1:0]                            rr_q, idx_a, idx_b, last;
   logic                                       vld_a, vld_b, rsv_zero, rsv_ready;
   logic [NumReq-1:0]                          gnt;
   logic [NumRfWrPorts-1:0]                    we_q;
   logic [NumRfWrPorts-1:0][RfAddrW-1:0]       waddr_q;
   logic [NumRfWrPorts-1:0][DataWidth-1:0]     wdata_q;
   logic [NumRegs-1:0]                         busy_q, busy_d;
   cve2_rf_rr_pick2 #(.NumReq(NumReq), .IdxW(IdxW)) u_pick (
      .valid_i (bus.req_valid_i),
      .addr_i  (bus.req_addr_i),
      .rr_i    (rr_q),
      .gnt_o   (gnt),
      .idx_a_o (idx_a),
      .idx_b_o (idx_b),
      .vld_b_o (vld_b)
   );
   assign vld_a           = |gnt;
   assign last            = vld_b ? idx_b : idx_a;
   assign bus.req_ready_o = gnt;
   assign rsv_zero        = is_zero_reg(bus.rsv_addr_i, RV32E);
   assign rsv_ready       = rsv_zero || !busy_q[bus.rsv_addr_i[RegW-1:0]];
   assign bus.rsv_ready_o = rsv_ready;
   assign bus.hz_a_o      = !is_zero_reg(bus.raddr_a_i, RV32E) && busy_q[bus.raddr_a_i[RegW-1:0]];
   assign bus.hz_b_o      = !is_zero_reg(bus.raddr_b_i, RV32E) && busy_q[bus.raddr_b_i[RegW-1:0]];
   assign bus.hz_c_o      = !is_zero_reg(bus.raddr_c_i, RV32E) && busy_q[bus.raddr_c_i[RegW-1:0]];
   assign bus.we_a_o      = we_q[0];
   assign bus.waddr_a_o   = waddr_q[0];
   assign bus.wdata_a_o   = wdata_q[0];
   assign bus.we_b_o      = we_q[1];
   assign bus.waddr_b_o   = waddr_q[1];
   assign bus.wdata_b_o   = wdata_q[1];
   // busy bits retire on the edge where the RF captures the write; flush overrides everything
   always_comb begin
      busy_d = busy_q;
      for (int p = 0; p < NumRfWrPorts; p++)
         if (we_q[p]) busy_d[waddr_q[p][RegW-1:0]] = 1'b0;
      if (bus.rsv_valid_i && rsv_ready && !rsv_zero) busy_d[bus.rsv_addr_i[RegW-1:0]] = 1'b1;
      if (bus.flush_i) busy_d = '0;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q    <= '0;
         we_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         busy_q  <= '0;
      end else begin
         if (vld_a) rr_q <= IdxW'((int'(last) + 1) % NumReq);
         we_q[0]    <= vld_a && !is_zero_reg(bus.req_addr_i[idx_a], RV32E);
         we_q[1]    <= vld_b && !is_zero_reg(bus.req_addr_i[idx_b], RV32E);
         waddr_q[0] <= vld_a ? bus.req_addr_i[idx_a] : '0;
         waddr_q[1] <= vld_b ? bus.req_addr_i[idx_b] : '0;
         wdata_q[0] <= vld_a ? bus.req_data_i[idx_a] : '0;
         wdata_q[1] <= vld_b ? bus.req_data_i[idx_b] : '0;
         busy_q     <= busy_d;
      end
   end
endmodule

// File: doc/cve2_rf_wb_arbiter.md
Name: cve2_rf_wb_arbiter

Overview:
- Writeback arbiter and scoreboard in front of the dual-write-port flip-flop register file.
- Accepts writeback requests from NumReq producers (ALU, LSU, multi-cycle unit) over valid/ready and grants up to two per cycle.
- Drives the register file write ports A and B through one registered stage.
- Tracks registers with pending writes so issue logic can stall on RAW/WAW hazards for the three read ports.

Parameters:
- RV32E, 0, 16-entry register space when 1; otherwise 32.
- DataWidth, 32, write data width.
- NumReq, 3, number of writeback requesters (2..4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  per-requester write request
- req_ready_o  out  NumReq  grant; transfer occurs when valid&&ready
- req_addr_i  in  NumReq x 5  destination register
- req_data_i  in  NumReq x DataWidth  write data
- we_a_o  out  1  register file port A write enable
- waddr_a_o  out  5  port A address
- wdata_a_o  out  DataWidth  port A data
- we_b_o  out  1  register file port B write enable
- waddr_b_o  out  5  port B address
- wdata_b_o  out  DataWidth  port B data
- rsv_valid_i  in  1  issue stage reserves a destination
- rsv_addr_i  in  5  register to reserve
- rsv_ready_o  out  1  reservation accepted
- flush_i  in  1  clear all reservations
- raddr_a_i / raddr_b_i / raddr_c_i  in  5 each  read addresses from decode
- hz_a_o / hz_b_o / hz_c_o  out  1 each  read address has a pending write

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. On reset, we_a_o=we_b_o=0, waddr_*=0, wdata_*=0, busy_q=0, rr_q=0.
- Arbitration is combinational within a cycle.
  - Scan requesters circularly starting at rr_q.
  - The first valid requester is granted port A.
  - The next valid requester whose addr differs from port A's addr is granted port B.
  - At most two grants per cycle. A same-address requester is not granted and waits.
- req_ready_o depends on req_valid_i; requesters must not make valid depend on ready.
- rr_q updates only when at least one grant occurs: it moves to (index of last granted requester + 1) mod NumReq.
- Output stage: a granted request appears on the port outputs in the next cycle (latency 1) for exactly one cycle. Ports deassert when there is no grant.
- Requests to x0 are granted and consume a slot, but the corresponding we_x_o stays 0.
- RV32E: addresses with bit 4 set are handled the same as x0.
- No backpressure from the register file; the output stage never stalls.
- Scoreboard busy_q has one bit per register; x0 is never busy.
  - rsv_ready_o = !busy_q[rsv_addr_i] || rsv_addr_i==0.
  - On rsv_valid_i && rsv_ready_o, set busy_q[rsv_addr_i] at the clock edge.
  - A reservation to a busy register is refused, so WAW reservations stall at issue.
  - A busy bit clears at the clock edge that ends the cycle in which we_a_o or we_b_o is asserted for that address. This is the same edge on which the register file captures the data.
  - A write to a non-reserved register is legal and leaves the scoreboard unchanged.
  - Set and clear cannot target the same register in one cycle, because reservation requires the bit to be clear.
- flush_i clears all busy bits on the next edge and has priority over a same-cycle reservation. Grants already in the output stage still write.
- Hazards: hz_x_o = busy_q[raddr_x_i] && raddr_x_i!=0. The output is combinational from busy_q and does not bypass in-flight data.
- Reset mid-operation drops all pending grants and reservations immediately.

Decomposition:
- Package cve2_rf_pkg:
  - RfAddrW=5.
  - NumRfWrPorts=2.
  - typedef rf_wr_t {logic [4:0] addr; logic [DataWidth-1:0] data; logic we}.
- Sub-module cve2_rf_rr_pick2: a combinational circular two-winner picker with the address-conflict filter. Inputs: valid, addrs, rr pointer. Outputs: grant vector, port A index, port B index, port B valid.
- All state (rr_q, output registers, busy_q) stays in cve2_rf_wb_arbiter.

Test Plan:
- Reset sequence → all outputs 0, rsv_ready_o=1 for any address, hz_*=0.
- Requesters 0,1,2 valid (addrs 5,6,7; data 0xA,0xB,0xC), rr_q=0:
  - Cycle 0: ready=3'b011.
  - Cycle 1: A=(5,0xA), B=(6,0xB); rr_q=2.
  - Cycle 1 grant of req2: port A=(7,0xC) appears in cycle 2.
- Requesters 0 and 1 both target x9, req1 also valid:
  - Cycle 0: only req0 is granted.
  - Next cycle: req1 is granted on port A.
  - we_b_o stays 0 throughout.
- Reserve x3, then set raddr_b_i=3:
  - hz_b_o=1.
  - A second rsv to x3 gives rsv_ready_o=0.
  - Writeback to x3: hz_b_o drops the cycle after we_a_o pulses.
- Request to x0 with data 0xFFFF → grant asserted, we_a_o stays 0 in the next cycle.
- Reserve x4 and x8, assert flush_i together with a rsv to x10 → busy_q=0 after the edge; x10 is not reserved.
